// File: rtl/kbd_pkg.sv
// Scan-code and character constants plus the scan-code to character translation
// shared by the keyboard character FIFO.
package kbd_pkg;

  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] SC_BKSP     = 8'h66;
  localparam logic [7:0] SC_SPACE    = 8'h29;
  localparam logic [7:0] SC_TAB      = 8'h0D;
  localparam logic [7:0] SC_ESC      = 8'h76;
  localparam logic [7:0] SC_E0_UP    = 8'h75;
  localparam logic [7:0] SC_E0_DOWN  = 8'h72;
  localparam logic [7:0] SC_E0_LEFT  = 8'h6B;
  localparam logic [7:0] SC_E0_RIGHT = 8'h74;
  localparam logic [7:0] SC_E0_DEL   = 8'h71;

  localparam logic [7:0] CH_UP    = 8'h80;
  localparam logic [7:0] CH_DOWN  = 8'h81;
  localparam logic [7:0] CH_LEFT  = 8'h82;
  localparam logic [7:0] CH_RIGHT = 8'h83;
  localparam logic [7:0] CH_DEL   = 8'h7F;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_ESC   = 8'h1B;

  typedef struct packed {
    logic       mapped;
    logic [7:0] ch;
  } xlat_t;

  function automatic xlat_t translate(input logic [7:0] code, input logic e0,
                                      input logic shift, input logic ctrl,
                                      input logic caps);
    xlat_t      r;
    logic       is_letter;
    logic       is_sym;
    logic [4:0] idx;
    logic [7:0] lo;
    logic [7:0] hi;
    r         = '0;
    is_letter = 1'b0;
    is_sym    = 1'b0;
    idx       = '0;
    lo        = '0;
    hi        = '0;
    if (e0) begin
      r.mapped = 1'b1;
      case (code)
        SC_E0_UP:    r.ch = CH_UP;
        SC_E0_DOWN:  r.ch = CH_DOWN;
        SC_E0_LEFT:  r.ch = CH_LEFT;
        SC_E0_RIGHT: r.ch = CH_RIGHT;
        SC_E0_DEL:   r.ch = CH_DEL;
        SC_ENTER:    r.ch = CH_CR;
        default:     r.mapped = 1'b0;
      endcase
    end else begin
      is_letter = 1'b1;
      case (code)
        8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;
        8'h23: idx = 5'd3;   8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;
        8'h34: idx = 5'd6;   8'h33: idx = 5'd7;   8'h43: idx = 5'd8;
        8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
        8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;
        8'h4D: idx = 5'd15;  8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;
        8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;  8'h3C: idx = 5'd20;
        8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
        8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
        default: is_letter = 1'b0;
      endcase
      // US layout: unshifted / shifted pairs for the main-block symbol keys
      is_sym = 1'b1;
      case (code)
        8'h45: begin lo = "0";  hi = ")"; end
        8'h16: begin lo = "1";  hi = "!"; end
        8'h1E: begin lo = "2";  hi = "@"; end
        8'h26: begin lo = "3";  hi = "#"; end
        8'h25: begin lo = "4";  hi = "$"; end
        8'h2E: begin lo = "5";  hi = "%"; end
        8'h36: begin lo = "6";  hi = "^"; end
        8'h3D: begin lo = "7";  hi = "&"; end
        8'h3E: begin lo = "8";  hi = "*"; end
        8'h46: begin lo = "9";  hi = "("; end
        8'h0E: begin lo = 8'h60; hi = "~"; end
        8'h4E: begin lo = "-";  hi = "_"; end
        8'h55: begin lo = "=";  hi = "+"; end
        8'h54: begin lo = "[";  hi = "{"; end
        8'h5B: begin lo = "]";  hi = "}"; end
        8'h5D: begin lo = "\\"; hi = "|"; end
        8'h4C: begin lo = ";";  hi = ":"; end
        8'h52: begin lo = "'";  hi = "\""; end
        8'h41: begin lo = ",";  hi = "<"; end
        8'h49: begin lo = ".";  hi = ">"; end
        8'h4A: begin lo = "/";  hi = "?"; end
        SC_SPACE: begin lo = CH_SP;  hi = CH_SP;  end
        SC_ENTER: begin lo = CH_CR;  hi = CH_CR;  end
        SC_BKSP:  begin lo = CH_BS;  hi = CH_BS;  end
        SC_TAB:   begin lo = CH_TAB; hi = CH_TAB; end
        SC_ESC:   begin lo = CH_ESC; hi = CH_ESC; end
        default:  is_sym = 1'b0;
      endcase
      if (is_letter) begin
        r.mapped = 1'b1;
        if (ctrl)              r.ch = {3'b000, idx} + 8'h01;
        else if (shift ^ caps) r.ch = {3'b000, idx} + 8'h41;
        else                   r.ch = {3'b000, idx} + 8'h61;
      end else if (is_sym) begin
        r.mapped = 1'b1;
        r.ch     = shift ? hi : lo;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/kbd_char_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy and a sticky overflow flag.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count,
  output logic              overflow
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];

  // A pop frees the head slot in the same edge, so a full FIFO still accepts a push
  always_comb begin
    do_pop     = rd_en && !empty;
    do_push    = wr_en && (!full || do_pop);
    overflow_d = overflow_q || (wr_en && full && !do_pop);
    wr_ptr_d   = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d    = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/kbd_char_fifo.sv
// Keyboard character queue: tracks plain/E0 source, translates each key event to a
// character in a two-stage pipeline and buffers it for the consumer.
module kbd_char_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  scanCode,
  input  logic [7:0]  scanCode_E0,
  input  logic        shift,
  input  logic        ctrl,
  input  logic        capslock,
  input  logic        newKey,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        empty,
  output logic        full,
  output logic [AW:0] count,
  output logic        overflow
);

  logic [7:0] sc_shadow_q, sc_shadow_d;
  logic [7:0] e0_shadow_q, e0_shadow_d;
  logic       src_e0_q, src_e0_d;
  logic [7:0] sel_code;

  logic       vld_p1_q, vld_p1_d;
  logic [7:0] code_p1_q, code_p1_d;
  logic       e0_p1_q, e0_p1_d;
  logic       shift_p1_q, shift_p1_d;
  logic       ctrl_p1_q, ctrl_p1_d;
  logic       caps_p1_q, caps_p1_d;

  logic       vld_p2_q, vld_p2_d;
  logic [7:0] ch_p2_q, ch_p2_d;
  xlat_t      xl;

  // Source tracking: the E0 check comes last so it wins a simultaneous change
  always_comb begin
    sc_shadow_d = scanCode;
    e0_shadow_d = scanCode_E0;
    src_e0_d    = src_e0_q;
    if (scanCode != sc_shadow_q && scanCode != 8'h00)       src_e0_d = 1'b0;
    if (scanCode_E0 != e0_shadow_q && scanCode_E0 != 8'h00) src_e0_d = 1'b1;
    sel_code = src_e0_d ? scanCode_E0 : scanCode;
  end

  // Stage p1: capture the selected code and modifier levels
  always_comb begin
    vld_p1_d   = newKey && (sel_code != 8'h00);
    code_p1_d  = sel_code;
    e0_p1_d    = src_e0_d;
    shift_p1_d = shift;
    ctrl_p1_d  = ctrl;
    caps_p1_d  = capslock;
  end

  // Stage p2: translate; unmapped codes drop out here
  always_comb begin
    xl       = translate(code_p1_q, e0_p1_q, shift_p1_q, ctrl_p1_q, caps_p1_q);
    vld_p2_d = vld_p1_q && xl.mapped;
    ch_p2_d  = xl.ch;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sc_shadow_q <= '0;
      e0_shadow_q <= '0;
      src_e0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
    end else begin
      sc_shadow_q <= sc_shadow_d;
      e0_shadow_q <= e0_shadow_d;
      src_e0_q    <= src_e0_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    code_p1_q  <= code_p1_d;
    e0_p1_q    <= e0_p1_d;
    shift_p1_q <= shift_p1_d;
    ctrl_p1_q  <= ctrl_p1_d;
    caps_p1_q  <= caps_p1_d;
    ch_p2_q    <= ch_p2_d;
  end

  // Stage p3: push into the queue
  sync_fifo #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .DATA_W (8)
  ) u_fifo (
    .clk      (clk),
    .clr      (clr),
    .wr_en    (vld_p2_q),
    .wr_data  (ch_p2_q),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_kbd_char_fifo.sv
// Directed bench for kbd_char_fifo: translation, source tracking, fill/overflow,
// wrap-around drain and mid-flight reset.
module tb_kbd_char_fifo;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] scanCode, scanCode_E0;
  logic       shift, ctrl, capslock, newKey, rd_en;
  logic [7:0] rd_data;
  logic       empty, full, overflow;
  logic [4:0] count;

  int errors = 0;
  int checks = 0;

  kbd_char_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk         (clk),
    .clr         (clr),
    .scanCode    (scanCode),
    .scanCode_E0 (scanCode_E0),
    .shift       (shift),
    .ctrl        (ctrl),
    .capslock    (capslock),
    .newKey      (newKey),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe one key event; with pop=1, rd_en is high in the cycle the push lands.
  // Returns at the falling edge just after the push edge.
  task automatic key(input logic [7:0] sc, input logic [7:0] sce0, input logic sh,
                     input logic ct, input logic cp, input logic pop);
    @(negedge clk);
    scanCode = sc; scanCode_E0 = sce0; shift = sh; ctrl = ct; capslock = cp;
    newKey = 1'b1;
    @(negedge clk);
    newKey = 1'b0;
    @(negedge clk);
    rd_en = pop;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk(tag, {24'h0, rd_data}, {24'h0, exp});
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  logic [7:0] first_exp [9]  = '{8'h61, 8'h61, 8'h41, 8'h01, 8'h21, 8'h20, 8'h80, 8'h61, 8'h61};
  logic [7:0] fill_sc   [17] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15};
  logic [7:0] drain_exp [16] = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69,
                                 8'h6A, 8'h6B, 8'h6C, 8'h6D, 8'h6E, 8'h6F, 8'h70, 8'h72};

  initial begin
    clr = 1'b1; scanCode = 8'h00; scanCode_E0 = 8'h00;
    shift = 1'b0; ctrl = 1'b0; capslock = 1'b0; newKey = 1'b0; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_empty", {31'h0, empty}, 32'd1);
    chk("reset_full", {31'h0, full}, 32'd0);
    chk("reset_count", {27'h0, count}, 32'd0);
    chk("reset_overflow", {31'h0, overflow}, 32'd0);
    chk("reset_rd_data", {24'h0, rd_data}, 32'h0);
    clr = 1'b0;

    // first key with latency probe: still empty at N+2, visible at N+3
    @(negedge clk);
    scanCode = 8'h1C; newKey = 1'b1;
    @(negedge clk);
    newKey = 1'b0;
    @(negedge clk);
    chk("lat_empty_n2", {31'h0, empty}, 32'd1);
    @(negedge clk);
    chk("lat_empty_n3", {31'h0, empty}, 32'd0);
    chk("lat_rd_data", {24'h0, rd_data}, 32'h61);
    chk("lat_count", {27'h0, count}, 32'd1);

    key(8'h1C, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    key(8'h1C, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    key(8'h1C, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    key(8'h16, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    key(8'h29, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    key(8'h29, 8'h75, 1'b0, 1'b0, 1'b0, 1'b0);
    key(8'h1C, 8'h75, 1'b0, 1'b0, 1'b0, 1'b0);
    key(8'h1C, 8'h75, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("seq_count", {27'h0, count}, 32'd9);
    for (int i = 0; i < 9; i++) pop_chk($sformatf("seq_pop%0d", i), first_exp[i]);
    @(negedge clk);
    chk("seq_drained", {31'h0, empty}, 32'd1);

    key(8'h12, 8'h75, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("unmapped_shift", {27'h0, count}, 32'd0);
    key(8'h12, 8'h70, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("unmapped_e0_70", {27'h0, count}, 32'd0);

    for (int i = 0; i < 16; i++) key(fill_sc[i], 8'h70, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fill_full", {31'h0, full}, 32'd1);
    chk("fill_count", {27'h0, count}, 32'd16);
    chk("fill_no_ovf", {31'h0, overflow}, 32'd0);
    key(fill_sc[16], 8'h70, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", {31'h0, overflow}, 32'd1);
    chk("ovf_count", {27'h0, count}, 32'd16);
    chk("ovf_head", {24'h0, rd_data}, 32'h61);
    key(8'h2D, 8'h70, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fullpp_count", {27'h0, count}, 32'd16);
    chk("fullpp_ovf", {31'h0, overflow}, 32'd1);
    chk("fullpp_head", {24'h0, rd_data}, 32'h62);

    for (int i = 0; i < 16; i++) pop_chk($sformatf("drain%0d", i), drain_exp[i]);
    @(negedge clk);
    chk("drain_empty", {31'h0, empty}, 32'd1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    chk("idle_pop_count", {27'h0, count}, 32'd0);
    chk("idle_pop_empty", {31'h0, empty}, 32'd1);
    chk("idle_pop_rd_data", {24'h0, rd_data}, 32'h0);

    key(8'h1C, 8'h70, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("emptypp_count", {27'h0, count}, 32'd1);
    chk("emptypp_head", {24'h0, rd_data}, 32'h61);
    key(8'h32, 8'h70, 1'b0, 1'b0, 1'b0, 1'b0);
    key(8'h21, 8'h70, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_clr_count", {27'h0, count}, 32'd3);

    // fourth character in flight (past p1) when clr hits
    @(negedge clk);
    scanCode = 8'h23; newKey = 1'b1;
    @(negedge clk);
    newKey = 1'b0;
    clr = 1'b1;
    #1;
    chk("clr_count", {27'h0, count}, 32'd0);
    chk("clr_empty", {31'h0, empty}, 32'd1);
    chk("clr_overflow", {31'h0, overflow}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_clr_count", {27'h0, count}, 32'd0);
    chk("post_clr_empty", {31'h0, empty}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
